// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: ICache refills and DCache refills/write-backs share one
// memory port. Requests are latched, then granted round-robin through IDLE -> ISSUE -> WAIT.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         icache_valid_req_i,
  input  logic [31:0]  icache_addr_i,
  output logic         icache_ready_o,
  output logic [127:0] icache_data_o,
  input  logic         dcache_valid_req_i,
  input  logic         dcache_we_i,
  input  logic [31:0]  dcache_addr_i,
  input  logic [127:0] dcache_wdata_i,
  output logic         dcache_ready_o,
  output logic [127:0] dcache_data_o,
  output logic         mem_valid_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_wdata_o,
  input  logic         mem_ready_i,
  input  logic [127:0] mem_data_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_e        state_q;
  logic          ipend_q, dpend_q;
  logic [31:4]   iaddr_q, daddr_q;
  logic          dwe_q;
  logic [127:0]  dwdata_q;
  logic          gnt_q, last_q;
  logic [31:0]   maddr_q;
  logic          mwe_q;
  logic [127:0]  mwdata_q;

  logic done, i_busy, d_busy, i_take, d_take, gnt_d;
  logic unused_addr_lsbs;

  // Block addresses only; the byte offset within a 16-byte block is dropped.
  assign unused_addr_lsbs = ^{icache_addr_i[3:0], dcache_addr_i[3:0]};

  assign done = (state_q == WAIT) && mem_ready_i;
  // A completing requester may re-request on its completion cycle.
  assign i_busy = ipend_q || ((state_q != IDLE) && (gnt_q == GNT_I) && !done);
  assign d_busy = dpend_q || ((state_q != IDLE) && (gnt_q == GNT_D) && !done);
  assign i_take = icache_valid_req_i && !i_busy;
  assign d_take = dcache_valid_req_i && !d_busy;
  assign gnt_d  = (dpend_q && (!ipend_q || (last_q == GNT_I))) ? GNT_D : GNT_I;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ipend_q  <= 1'b0;
      dpend_q  <= 1'b0;
      iaddr_q  <= '0;
      daddr_q  <= '0;
      dwe_q    <= 1'b0;
      dwdata_q <= '0;
      gnt_q    <= GNT_I;
      last_q   <= GNT_I;
      maddr_q  <= '0;
      mwe_q    <= 1'b0;
      mwdata_q <= '0;
    end else begin
      ipend_q <= i_take || (ipend_q && !((state_q == ISSUE) && (gnt_q == GNT_I)));
      dpend_q <= d_take || (dpend_q && !((state_q == ISSUE) && (gnt_q == GNT_D)));
      if (i_take) iaddr_q <= icache_addr_i[31:4];
      if (d_take) begin
        daddr_q  <= dcache_addr_i[31:4];
        dwe_q    <= dcache_we_i;
        dwdata_q <= dcache_wdata_i;
      end
      case (state_q)
        IDLE: if (ipend_q || dpend_q) begin
          state_q  <= ISSUE;
          gnt_q    <= gnt_d;
          maddr_q  <= {(gnt_d == GNT_D) ? daddr_q : iaddr_q, 4'b0};
          mwe_q    <= (gnt_d == GNT_D) && dwe_q;
          mwdata_q <= (gnt_d == GNT_D) ? dwdata_q : '0;
        end
        ISSUE: begin
          state_q <= WAIT;
          last_q  <= gnt_q;
        end
        WAIT: if (mem_ready_i) begin
          state_q  <= IDLE;
          maddr_q  <= '0;
          mwe_q    <= 1'b0;
          mwdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_valid_req_o = (state_q == ISSUE);
  assign mem_we_o        = mwe_q;
  assign mem_addr_o      = maddr_q;
  assign mem_wdata_o     = mwdata_q;
  assign icache_ready_o  = done && (gnt_q == GNT_I);
  assign dcache_ready_o  = done && (gnt_q == GNT_D);
  assign icache_data_o   = icache_ready_o ? mem_data_i : '0;
  assign dcache_data_o   = dcache_ready_o ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus a hand-written
// mid-transaction reset sequence.
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         icache_valid_req_i = 0;
  logic [31:0]  icache_addr_i = 0;
  logic         icache_ready_o;
  logic [127:0] icache_data_o;
  logic         dcache_valid_req_i = 0;
  logic         dcache_we_i = 0;
  logic [31:0]  dcache_addr_i = 0;
  logic [127:0] dcache_wdata_i = 0;
  logic         dcache_ready_o;
  logic [127:0] dcache_data_o;
  logic         mem_valid_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_ready_i = 0;
  logic [127:0] mem_data_i = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_valid_req_i(icache_valid_req_i), .icache_addr_i(icache_addr_i),
    .icache_ready_o(icache_ready_o), .icache_data_o(icache_data_o),
    .dcache_valid_req_i(dcache_valid_req_i), .dcache_we_i(dcache_we_i),
    .dcache_addr_i(dcache_addr_i), .dcache_wdata_i(dcache_wdata_i),
    .dcache_ready_o(dcache_ready_o), .dcache_data_o(dcache_data_o),
    .mem_valid_req_o(mem_valid_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i)
  );

  localparam logic [127:0] Z  = '0;
  localparam logic [127:0] W1 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] W2 = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
  localparam logic [127:0] M1 = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
  localparam logic [127:0] M2 = 128'h0F0F0F0F_F0F0F0F0_12121212_34343434;
  localparam logic [127:0] M3 = 128'h55AA55AA_AA55AA55_99999999_66666666;
  localparam logic [127:0] M4 = 128'hFEDCBA98_76543210_FFFFFFFF_00000001;
  localparam logic [127:0] M5 = 128'h13579BDF_2468ACE0_13579BDF_2468ACE0;

  typedef struct {
    logic r, iv; logic [31:0] ia;
    logic dv, dwe; logic [31:0] da; logic [127:0] dw;
    logic mr; logic [127:0] md;
    logic evld, ewe; logic [31:0] eaddr; logic [127:0] ewd;
    logic eir, edr;
  } vec_t;

  vec_t tbl[$];
  int pass_cnt = 0;
  int tot_cnt  = 0;

  wire [419:0] act = {mem_valid_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
                      icache_ready_o, icache_data_o, dcache_ready_o, dcache_data_o};

  function automatic vec_t row(input logic r, iv, input logic [31:0] ia,
                               input logic dv, dwe, input logic [31:0] da, input logic [127:0] dw,
                               input logic mr, input logic [127:0] md,
                               input logic evld, ewe, input logic [31:0] eaddr,
                               input logic [127:0] ewd, input logic eir, edr);
    vec_t v;
    v.r = r; v.iv = iv; v.ia = ia; v.dv = dv; v.dwe = dwe; v.da = da; v.dw = dw;
    v.mr = mr; v.md = md; v.evld = evld; v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd;
    v.eir = eir; v.edr = edr;
    return v;
  endfunction

  function automatic logic [419:0] expv(input logic vld, we, input logic [31:0] a,
                                        input logic [127:0] wd, input logic ir, dr,
                                        input logic [127:0] md);
    return {vld, we, a, wd, ir, ir ? md : Z, dr, dr ? md : Z};
  endfunction

  task automatic check(input string nm, input logic [419:0] e);
    tot_cnt++;
    if (act === e) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, e);
  endtask

  task automatic drive(input logic r, iv, input logic [31:0] ia, input logic dv, dwe,
                       input logic [31:0] da, input logic [127:0] dw,
                       input logic mr, input logic [127:0] md);
    rst = r; icache_valid_req_i = iv; icache_addr_i = ia;
    dcache_valid_req_i = dv; dcache_we_i = dwe; dcache_addr_i = da; dcache_wdata_i = dw;
    mem_ready_i = mr; mem_data_i = md;
  endtask

  initial begin
    // reset row, ICache-only flow, idle-ready
    tbl.push_back(row(1,1,32'h1234,1,1,32'h200,W1,1,M1, 0,0,0,Z,0,0));
    tbl.push_back(row(0,1,32'h1234,0,0,0,Z,0,Z,        0,0,0,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               0,0,0,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               1,0,32'h1230,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               0,0,32'h1230,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,1,M1,              0,0,32'h1230,Z,1,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,1,M2,              0,0,0,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               0,0,0,Z,0,0));
    // simultaneous I/D, DCache re-pulse while in flight, ready during ISSUE
    tbl.push_back(row(0,1,32'h100,1,1,32'h200,W1,0,Z,  0,0,0,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               0,0,0,Z,0,0));
    tbl.push_back(row(0,0,0,1,0,32'h300,Z,0,Z,         1,1,32'h200,W1,0,0));
    tbl.push_back(row(0,0,0,1,0,32'h300,Z,0,Z,         0,1,32'h200,W1,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,1,M2,              0,1,32'h200,W1,0,1));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               0,0,0,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,1,M3,              1,0,32'h100,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,1,M3,              0,0,32'h100,Z,1,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               0,0,0,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               0,0,0,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               0,0,0,Z,0,0));
    // fairness: re-request on completion, grants go D, I, D, I
    tbl.push_back(row(0,1,32'h400,1,0,32'h500,Z,0,Z,   0,0,0,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               0,0,0,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               1,0,32'h500,Z,0,0));
    tbl.push_back(row(0,0,0,1,0,32'h600,Z,1,M4,        0,0,32'h500,Z,0,1));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               0,0,0,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               1,0,32'h400,Z,0,0));
    tbl.push_back(row(0,1,32'h700,0,0,0,Z,1,M1,        0,0,32'h400,Z,1,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               0,0,0,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               1,0,32'h600,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,1,M2,              0,0,32'h600,Z,0,1));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               0,0,0,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               1,0,32'h700,Z,0,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,1,M3,              0,0,32'h700,Z,1,0));
    tbl.push_back(row(0,0,0,0,0,0,Z,0,Z,               0,0,0,Z,0,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].iv, tbl[i].ia, tbl[i].dv, tbl[i].dwe, tbl[i].da, tbl[i].dw,
            tbl[i].mr, tbl[i].md);
      #1 check($sformatf("row%0d", i),
               expv(tbl[i].evld, tbl[i].ewe, tbl[i].eaddr, tbl[i].ewd, tbl[i].eir, tbl[i].edr,
                    tbl[i].md));
    end

    // reset during WAIT abandons the transaction and clears queued requests
    @(negedge clk); drive(0,0,0,1,1,32'h800,W2,0,Z);
    @(negedge clk); drive(0,0,0,0,0,0,Z,0,Z);
    @(negedge clk); drive(0,1,32'h900,0,0,0,Z,0,Z);
    #1 check("rst_seq_issue", expv(1,1,32'h800,W2,0,0,Z));
    @(negedge clk); drive(0,0,0,0,0,0,Z,0,Z);
    #1 check("rst_seq_wait", expv(0,1,32'h800,W2,0,0,Z));
    #2 drive(1,0,0,0,0,0,Z,1,M5);
    #1 check("rst_async", expv(0,0,0,Z,0,0,Z));
    @(negedge clk); drive(0,0,0,0,0,0,Z,1,M5);
    #1 check("rst_late_ready", expv(0,0,0,Z,0,0,Z));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check($sformatf("rst_quiet%0d", k), expv(0,0,0,Z,0,0,Z));
    end
    // last_grant is back to ICache, so DCache wins the tie
    @(negedge clk); drive(0,1,32'hA04,1,0,32'hB08,Z,0,Z);
    @(negedge clk); drive(0,0,0,0,0,0,Z,0,Z);
    @(negedge clk);
    #1 check("post_rst_grant_d", expv(1,0,32'hB00,Z,0,0,Z));
    @(negedge clk); drive(0,0,0,0,0,0,Z,1,M4);
    #1 check("post_rst_d_done", expv(0,0,32'hB00,Z,0,1,M4));
    @(negedge clk); drive(0,0,0,0,0,0,Z,0,Z);
    @(negedge clk);
    #1 check("post_rst_grant_i", expv(1,0,32'hA00,Z,0,0,Z));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
